// File: rtl/mc_cpu_core.sv
// Multicycle CPU core: register file, ALU, data memory and control FSM.
// Runs one instruction at a time, accepted over a valid/ready handshake.
module mc_cpu_core #(
  parameter  int DATA_WIDTH  = 8,
  parameter  int ADDR_BITS   = 8,
  parameter  int REG_COUNT   = 4,
  localparam int RIDX        = $clog2(REG_COUNT),
  localparam int INSTR_WIDTH = 2 + 3*RIDX + DATA_WIDTH + 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            instr_valid,
  output logic                            instr_ready,
  input  logic [INSTR_WIDTH-1:0]          instr,
  output logic                            done,
  output logic                            err,
  output logic                            zero_flag,
  output logic [REG_COUNT*DATA_WIDTH-1:0] regs_out
);

  localparam int RIDXS = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DECODE     = 3'd1,
    EXECUTE    = 3'd2,
    MEM_ACCESS = 3'd3,
    WRITE_BACK = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    T_NOP   = 2'b00,
    T_ALU   = 2'b01,
    T_LOAD  = 2'b10,
    T_STORE = 2'b11
  } itype_t;

  state_t                  state, state_next;
  logic [INSTR_WIDTH-1:0]  ir;
  logic [DATA_WIDTH-1:0]   regs [REG_COUNT];
  logic [DATA_WIDTH-1:0]   mem  [2**ADDR_BITS];
  logic [DATA_WIDTH-1:0]   op_a, op_b, op_d;
  logic [DATA_WIDTH-1:0]   ex_res, rdata, alu_out, wb_data;
  logic                    ex_ill;
  itype_t                  ty_f;
  logic [RIDX-1:0]         rd_f, rs1_f, rs2_f;
  logic [DATA_WIDTH-1:0]   off_f;
  logic [3:0]              opc_f;
  logic [ADDR_BITS-1:0]    mem_addr;
  logic                    accept, reg_we, mem_we, zf_we, done_next, err_next;

  assign ty_f   = itype_t'(ir[INSTR_WIDTH-1 -: 2]);
  assign rd_f   = ir[INSTR_WIDTH-3 -: RIDX];
  assign rs1_f  = ir[INSTR_WIDTH-3-RIDX -: RIDX];
  assign rs2_f  = ir[INSTR_WIDTH-3-2*RIDX -: RIDX];
  assign off_f  = ir[4 +: DATA_WIDTH];
  assign opc_f  = ir[3:0];

  assign instr_ready = (state == IDLE);
  assign accept      = instr_valid && instr_ready;

  // ex_res holds either the ALU result or the effective address
  assign mem_addr = ADDR_BITS'(ex_res);
  assign wb_data  = (ty_f == T_LOAD) ? rdata : ex_res;

  always_comb begin
    alu_out = '0;
    case (opc_f)
      4'd0:    alu_out = op_a + op_b;
      4'd1:    alu_out = op_a - op_b;
      4'd2:    alu_out = op_a & op_b;
      4'd3:    alu_out = op_a | op_b;
      4'd4:    alu_out = op_a ^ op_b;
      4'd5:    alu_out = op_a << op_b[RIDXS-1:0];
      4'd6:    alu_out = op_a >> op_b[RIDXS-1:0];
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    zf_we      = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: if (accept) state_next = DECODE;
      DECODE: begin
        if (ty_f == T_NOP) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = EXECUTE;
        end
      end
      EXECUTE: state_next = (ty_f == T_ALU) ? WRITE_BACK : MEM_ACCESS;
      MEM_ACCESS: begin
        if (ty_f == T_STORE) begin
          mem_we     = 1'b1;
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = WRITE_BACK;
        end
      end
      WRITE_BACK: begin
        state_next = IDLE;
        done_next  = 1'b1;
        if (ty_f == T_ALU && ex_ill) begin
          err_next = 1'b1;
        end else begin
          reg_we = 1'b1;
          zf_we  = (ty_f == T_ALU);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ir        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_d      <= '0;
      ex_res    <= '0;
      ex_ill    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      zero_flag <= 1'b0;
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= DATA_WIDTH'(i);
    end else begin
      state <= state_next;
      done  <= done_next;
      err   <= err_next;
      if (accept) ir <= instr;
      if (state == DECODE) begin
        op_a <= regs[rs1_f];
        op_b <= regs[rs2_f];
        op_d <= regs[rd_f];
      end
      if (state == EXECUTE) begin
        ex_res <= (ty_f == T_ALU) ? alu_out : op_a + off_f;
        ex_ill <= (opc_f > 4'd6);
      end
      if (reg_we) regs[rd_f] <= wb_data;
      if (zf_we)  zero_flag  <= (wb_data == '0);
    end
  end

  // Memory has no reset so its contents survive rst
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= op_d;
    if (state == MEM_ACCESS) rdata <= mem[mem_addr];
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_regs_out
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed testbench for mc_cpu_core at default parameters.
module tb_mc_cpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [19:0] instr = '0;
  logic        done, err, zero_flag;
  logic [31:0] regs_out;

  int vectors    = 0;
  int miscompares = 0;

  localparam logic [1:0] NOP = 2'b00, ALU = 2'b01, LD = 2'b10, ST = 2'b11;

  mc_cpu_core #(.DATA_WIDTH(8), .ADDR_BITS(8), .REG_COUNT(4)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .done(done), .err(err), .zero_flag(zero_flag), .regs_out(regs_out)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] mk(input logic [1:0] t, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [1:0] rs2,
                                     input logic [7:0] off, input logic [3:0] op);
    return {t, rd, rs1, rs2, off, op};
  endfunction

  task automatic do_reset;
    rst = 1'b1;
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Issue one instruction from a negedge with the core idle; returns at the
  // negedge where done is seen. lat counts cycles with the accept cycle as 0.
  task automatic run_instr(input logic [19:0] ins, output int lat,
                           output logic e, output logic rdy1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    lat  = 1;
    rdy1 = instr_ready;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = err;
  endtask

  task automatic test_reset;
    do_reset;
    vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b want 1", instr_ready); end
    vectors++; if (regs_out !== 32'h03020100) begin miscompares++; $display("FAIL rst_regs got %h want 03020100", regs_out); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b want 0", err); end
    vectors++; if (zero_flag !== 1'b0) begin miscompares++; $display("FAIL rst_zf got %b want 0", zero_flag); end
  endtask

  task automatic test_nop;
    int lat; logic e, r1;
    do_reset;
    run_instr(mk(NOP, 2'd3, 2'd1, 2'd2, 8'h00, 4'd0), lat, e, r1);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL nop_lat got %0d want 2", lat); end
    vectors++; if (r1 !== 1'b0) begin miscompares++; $display("FAIL nop_ready_drop got %b want 0", r1); end
    vectors++; if (regs_out !== 32'h03020100) begin miscompares++; $display("FAIL nop_regs got %h want 03020100", regs_out); end
  endtask

  task automatic test_alu;
    logic [19:0] prog  [8];
    logic [31:0] exp_r [8];
    logic        exp_z [8];
    int lat; logic e, r1;
    prog  = '{mk(ALU,3,1,2,0,0), mk(ALU,0,1,2,0,1), mk(ALU,2,0,3,0,2), mk(ALU,1,1,2,0,3),
              mk(ALU,3,2,1,0,1), mk(ALU,0,0,1,0,6), mk(ALU,1,1,1,0,0), mk(ALU,2,1,0,0,4)};
    exp_r = '{32'h03020100, 32'h030201FF, 32'h030301FF, 32'h030303FF,
              32'h000303FF, 32'h0003031F, 32'h0003061F, 32'h0019061F};
    exp_z = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset;
    for (int i = 0; i < 8; i++) begin
      run_instr(prog[i], lat, e, r1);
      vectors++; if (lat !== 4) begin miscompares++; $display("FAIL alu%0d_lat got %0d want 4", i, lat); end
      vectors++; if (regs_out !== exp_r[i]) begin miscompares++; $display("FAIL alu%0d_regs got %h want %h", i, regs_out, exp_r[i]); end
      vectors++; if (zero_flag !== exp_z[i]) begin miscompares++; $display("FAIL alu%0d_zf got %b want %b", i, zero_flag, exp_z[i]); end
      vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL alu%0d_err got %b want 0", i, e); end
    end
  endtask

  task automatic test_mem;
    int lat; logic e, r1;
    do_reset;
    run_instr(mk(ST, 2, 1, 0, 8'h10, 0), lat, e, r1);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL st_lat got %0d want 4", lat); end
    vectors++; if (regs_out !== 32'h03020100) begin miscompares++; $display("FAIL st_regs got %h want 03020100", regs_out); end
    run_instr(mk(LD, 0, 1, 0, 8'h10, 9), lat, e, r1);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL ld_lat got %0d want 5", lat); end
    vectors++; if (regs_out !== 32'h03020102) begin miscompares++; $display("FAIL ld_regs got %h want 03020102", regs_out); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL ld_err got %b want 0", e); end
    run_instr(mk(ST, 3, 0, 0, 8'h20, 0), lat, e, r1);
    run_instr(mk(LD, 1, 2, 0, 8'h20, 0), lat, e, r1);
    vectors++; if (regs_out !== 32'h03020302) begin miscompares++; $display("FAIL ld2_regs got %h want 03020302", regs_out); end
    vectors++; if (zero_flag !== 1'b0) begin miscompares++; $display("FAIL ld2_zf got %b want 0", zero_flag); end
  endtask

  task automatic test_wrap;
    int lat; logic e, r1;
    do_reset;
    run_instr(mk(ALU, 3, 0, 1, 0, 1), lat, e, r1);
    vectors++; if (regs_out !== 32'hFF020100) begin miscompares++; $display("FAIL wrap_sub got %h want FF020100", regs_out); end
    run_instr(mk(ALU, 0, 1, 3, 0, 5), lat, e, r1);
    vectors++; if (regs_out !== 32'hFF020180) begin miscompares++; $display("FAIL wrap_shl got %h want FF020180", regs_out); end
    run_instr(mk(ST, 2, 1, 0, 8'h00, 0), lat, e, r1);
    run_instr(mk(LD, 0, 3, 0, 8'h02, 0), lat, e, r1);
    vectors++; if (regs_out !== 32'hFF020102) begin miscompares++; $display("FAIL wrap_ld got %h want FF020102", regs_out); end
  endtask

  task automatic test_illegal;
    int lat, pulses; logic e, r1, busy_ready;
    do_reset;
    run_instr(mk(ALU, 3, 1, 1, 0, 1), lat, e, r1);
    vectors++; if (zero_flag !== 1'b1) begin miscompares++; $display("FAIL ill_pre_zf got %b want 1", zero_flag); end
    run_instr(mk(ALU, 2, 1, 1, 0, 9), lat, e, r1);
    vectors++; if (lat !== 4) begin miscompares++; $display("FAIL ill_lat got %0d want 4", lat); end
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL ill_err got %b want 1", e); end
    vectors++; if (regs_out !== 32'h00020100) begin miscompares++; $display("FAIL ill_regs got %h want 00020100", regs_out); end
    vectors++; if (zero_flag !== 1'b1) begin miscompares++; $display("FAIL ill_zf got %b want 1", zero_flag); end
    @(negedge clk);
    vectors++; if ({done, err} !== 2'b00) begin miscompares++; $display("FAIL ill_pulse got %b want 00", {done, err}); end
    // valid held through busy cycles with a different instruction presented
    instr = mk(ALU, 1, 1, 2, 0, 0);
    instr_valid = 1'b1;
    @(posedge clk);
    pulses = 0;
    busy_ready = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 2) instr = mk(ALU, 0, 2, 2, 0, 0);
      if (c < 4 && instr_ready === 1'b1) busy_ready = 1'b1;
      if (done === 1'b1) begin
        pulses++;
        instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    vectors++; if (busy_ready !== 1'b0) begin miscompares++; $display("FAIL hold_ready got %b want 0", busy_ready); end
    vectors++; if (pulses !== 1) begin miscompares++; $display("FAIL hold_pulses got %0d want 1", pulses); end
    vectors++; if (regs_out !== 32'h00020300) begin miscompares++; $display("FAIL hold_regs got %h want 00020300", regs_out); end
  endtask

  task automatic test_back_to_back;
    logic [19:0] ops [3];
    int pulses, last, cyc;
    ops = '{mk(ALU,0,1,2,0,0), mk(ALU,1,0,3,0,0), mk(ALU,2,1,0,0,1)};
    do_reset;
    instr = ops[0];
    instr_valid = 1'b1;
    @(posedge clk);
    pulses = 0; last = 0; cyc = 0;
    while (pulses < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        pulses++;
        last = cyc;
        if (pulses < 3) instr = ops[pulses];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    vectors++; if (pulses !== 3) begin miscompares++; $display("FAIL b2b_pulses got %0d want 3", pulses); end
    vectors++; if (last !== 12) begin miscompares++; $display("FAIL b2b_last_done got %0d want 12", last); end
    vectors++; if (regs_out !== 32'h03030603) begin miscompares++; $display("FAIL b2b_regs got %h want 03030603", regs_out); end
  endtask

  task automatic test_reset_mid_load;
    int lat, pulses; logic e, r1;
    do_reset;
    run_instr(mk(ALU, 2, 2, 3, 0, 0), lat, e, r1);
    vectors++; if (regs_out !== 32'h03050100) begin miscompares++; $display("FAIL rml_pre got %h want 03050100", regs_out); end
    instr = mk(LD, 0, 1, 0, 8'h10, 0);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++; if (instr_ready !== 1'b1) begin miscompares++; $display("FAIL rml_ready got %b want 1", instr_ready); end
    vectors++; if (regs_out !== 32'h03020100) begin miscompares++; $display("FAIL rml_regs got %h want 03020100", regs_out); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rml_done got %b want 0", done); end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    vectors++; if (pulses !== 0) begin miscompares++; $display("FAIL rml_stray_done got %0d want 0", pulses); end
    run_instr(mk(LD, 0, 1, 0, 8'h10, 0), lat, e, r1);
    vectors++; if (lat !== 5) begin miscompares++; $display("FAIL rml_ld_lat got %0d want 5", lat); end
    vectors++; if (regs_out !== 32'h03020102) begin miscompares++; $display("FAIL rml_mem got %h want 03020102", regs_out); end
  endtask

  initial begin
    test_reset;
    test_nop;
    test_alu;
    test_mem;
    test_wrap;
    test_illegal;
    test_back_to_back;
    test_reset_mid_load;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d vectors", vectors);
    $fatal(1, "watchdog");
  end

endmodule
